// File: rtl/wb_pkg.sv
// Shared widths, queue entry type and register-0 index for the writeback arbiter.
// Optional feature macro used by this block: WB_R0_DISCARD_EN.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_REG_W  = 4;

    localparam logic [WB_REG_W-1:0] WB_R0 = '0;

    typedef struct packed {
        logic [WB_REG_W-1:0]  rd;
        logic [WB_DATA_W-1:0] data;
        logic                 live;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order load-result queue with per-entry live bits, kill-by-register
// and two scoreboard match outputs.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  wb_entry_t           push_ent_i,
    input  logic                pop_i,
    input  logic                kill_i,
    input  logic [WB_REG_W-1:0] kill_reg_i,
    output wb_entry_t           head_o,
    output logic [CW-1:0]       count_o,
    input  logic [WB_REG_W-1:0] look1_i,
    input  logic [WB_REG_W-1:0] look2_i,
    output logic                hit1_o,
    output logic                hit2_o
);

    wb_entry_t        ent_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && ent_q[i].rd == kill_reg_i) begin
                live_d[i] = 1'b0;
            end
        end
        // A popped slot is cleared so stale entries never hit the scoreboard.
        if (pop_i) begin
            live_d[rd_q] = 1'b0;
        end
        if (push_i) begin
            live_d[wr_q] = push_ent_i.live;
        end
        rd_d  = pop_i ? rd_q + AW'(1) : rd_q;
        wr_d  = push_i ? wr_q + AW'(1) : wr_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
        end else begin
            live_q <= live_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            ent_q[wr_q] <= push_ent_i;
        end
    end

    always_comb begin
        hit1_o = 1'b0;
        hit2_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && ent_q[i].rd == look1_i) hit1_o = 1'b1;
            if (live_q[i] && ent_q[i].rd == look2_i) hit2_o = 1'b1;
        end
    end

    assign head_o  = '{rd: ent_q[rd_q].rd,
                       data: ent_q[rd_q].data,
                       live: live_q[rd_q]};
    assign count_o = cnt_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU and load writebacks into one registered register-file write port.
// Define WB_R0_DISCARD_EN to drop all writes aimed at register 0.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = WB_DATA_W,
    parameter  int REG_W  = WB_REG_W,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_W-1:0]  mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic [REG_W-1:0]  DstReg,
    output logic              WriteReg,
    output logic [DATA_W-1:0] DstData,
    input  logic [REG_W-1:0]  pend_reg1,
    input  logic [REG_W-1:0]  pend_reg2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic [CW-1:0]     count
);

    logic              wr_q, wr_d;
    logic [REG_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic      keep_alu, keep_mem, look1_ok, look2_ok;
    logic      empty, accept, pop, bypass, push;
    logic      fhit1, fhit2;
    wb_entry_t head, push_ent;

`ifdef WB_R0_DISCARD_EN
    assign keep_alu = alu_reg != WB_R0;
    assign keep_mem = mem_reg != WB_R0;
    assign look1_ok = pend_reg1 != WB_R0;
    assign look2_ok = pend_reg2 != WB_R0;
`else
    assign keep_alu = 1'b1;
    assign keep_mem = 1'b1;
    assign look1_ok = 1'b1;
    assign look2_ok = 1'b1;
`endif

    assign mem_ready = count != CW'(DEPTH);
    assign empty     = count == '0;
    assign accept    = mem_valid & mem_ready;
    assign pop       = !alu_valid & !empty;
    assign bypass    = !alu_valid & empty & mem_valid;
    assign push      = accept & !bypass & keep_mem;

    // A load arriving with an ALU result to the same register is older, so dead.
    assign push_ent = '{rd: mem_reg,
                        data: mem_data,
                        live: !(alu_valid && alu_reg == mem_reg)};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_ent_i (push_ent),
        .pop_i      (pop),
        .kill_i     (alu_valid),
        .kill_reg_i (alu_reg),
        .head_o     (head),
        .count_o    (count),
        .look1_i    (pend_reg1),
        .look2_i    (pend_reg2),
        .hit1_o     (fhit1),
        .hit2_o     (fhit2)
    );

    always_comb begin
        wr_d   = 1'b0;
        dst_d  = dst_q;
        data_d = data_q;
        unique case (1'b1)
            alu_valid: begin
                if (keep_alu) begin
                    wr_d   = 1'b1;
                    dst_d  = alu_reg;
                    data_d = alu_data;
                end
            end
            pop: begin
                if (head.live) begin
                    wr_d   = 1'b1;
                    dst_d  = head.rd;
                    data_d = head.data;
                end
            end
            bypass: begin
                if (keep_mem) begin
                    wr_d   = 1'b1;
                    dst_d  = mem_reg;
                    data_d = mem_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            dst_q  <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            dst_q  <= dst_d;
            data_q <= data_d;
        end
    end

    assign WriteReg = wr_q;
    assign DstReg   = dst_q;
    assign DstData  = data_q;

    assign pend_hit1 = look1_ok & (fhit1 | (wr_q & dst_q == pend_reg1));
    assign pend_hit2 = look2_ok & (fhit2 | (wr_q & dst_q == pend_reg2));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed vector table,
// multi-cycle hand sequences and a randomised run against a reference queue.
module tb_wb_write_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef WB_R0_DISCARD_EN
    localparam bit DISC = 1'b1;
`else
    localparam bit DISC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, mem_ready;
    logic [3:0]  alu_reg, mem_reg, DstReg, pend_reg1, pend_reg2;
    logic [15:0] alu_data, mem_data, DstData;
    logic        WriteReg, pend_hit1, pend_hit2;
    logic [2:0]  count;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_reg(mem_reg), .mem_data(mem_data),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .pend_reg1(pend_reg1), .pend_reg2(pend_reg2),
        .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .count(count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        av;
        logic [3:0]  ar;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  mr;
        logic [15:0] md;
        logic [3:0]  pr;
        logic        ewr;
        logic [3:0]  edst;
        logic [15:0] edata;
        logic [2:0]  ecnt;
        logic        erdy;
        logic        ehit;
    } vec_t;

    vec_t          vt[$];
    logic [19:0]   exp_q[$];
    wb_entry_t     mq[$];
    logic [15:0]   rf[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop();
        logic [19:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got write r%0d=%0h expected none",
                     DstReg, DstData);
        end else begin
            e = exp_q.pop_front();
            if ({DstReg, DstData} !== e) begin
                errors++;
                $display("FAIL sb_write: got r%0d=%0h expected r%0d=%0h",
                         DstReg, DstData, e[19:16], e[15:0]);
            end
        end
        rf[DstReg] = DstData;
    endtask

    function automatic void addv(input logic av, input logic [3:0] ar,
                                 input logic [15:0] ad, input logic mv,
                                 input logic [3:0] mr, input logic [15:0] md,
                                 input logic [3:0] pr, input logic ewr,
                                 input logic [3:0] edst,
                                 input logic [15:0] edata,
                                 input logic [2:0] ecnt, input logic erdy,
                                 input logic ehit);
        vt.push_back('{av, ar, ad, mv, mr, md, pr, ewr, edst, edata,
                       ecnt, erdy, ehit});
    endfunction

    task automatic drive(input logic av, input logic [3:0] ar,
                         input logic [15:0] ad, input logic mv,
                         input logic [3:0] mr, input logic [15:0] md);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
    endtask

    initial begin
        logic        m_wr;
        logic [3:0]  m_dst;
        logic        rdy, acc, ka, km, byp, mhit;
        wb_entry_t   e;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        pend_reg1 = 0; pend_reg2 = 0;
        foreach (rf[i]) rf[i] = '0;
        // single ALU write
        addv(1, 3, 16'h1234, 0, 0, 0,       3, 1, 3, 16'h1234, 0, 1, 1);
        addv(0, 0, 0,        0, 0, 0,       3, 0, 3, 16'h1234, 0, 1, 0);
        // queue fill behind sustained ALU writes
        addv(1, 1, 16'h00A0, 1, 5, 16'h0505, 5, 1, 1, 16'h00A0, 1, 1, 1);
        addv(1, 1, 16'h00A1, 1, 6, 16'h0606, 6, 1, 1, 16'h00A1, 2, 1, 1);
        addv(1, 1, 16'h00A2, 1, 7, 16'h0707, 7, 1, 1, 16'h00A2, 3, 1, 1);
        addv(1, 1, 16'h00A3, 1, 8, 16'h0808, 8, 1, 1, 16'h00A3, 4, 0, 1);
        addv(1, 1, 16'h00A4, 1, 9, 16'h0909, 9, 1, 1, 16'h00A4, 4, 0, 0);
        addv(1, 1, 16'h00A5, 1, 9, 16'h0909, 9, 1, 1, 16'h00A5, 4, 0, 0);
        addv(0, 0, 0,        1, 9, 16'h0909, 5, 1, 5, 16'h0505, 3, 1, 1);
        addv(0, 0, 0,        1, 9, 16'h0909, 9, 1, 6, 16'h0606, 3, 1, 1);
        addv(0, 0, 0,        0, 0, 0,       7, 1, 7, 16'h0707, 2, 1, 1);
        addv(0, 0, 0,        0, 0, 0,       8, 1, 8, 16'h0808, 1, 1, 1);
        addv(0, 0, 0,        0, 0, 0,       9, 1, 9, 16'h0909, 0, 1, 1);
        addv(0, 0, 0,        0, 0, 0,       9, 0, 9, 16'h0909, 0, 1, 0);
        // same-cycle conflict: load is older, pushed dead
        addv(1, 2, 16'h2222, 1, 2, 16'h1111, 2, 1, 2, 16'h2222, 1, 1, 1);
        addv(0, 0, 0,        0, 0, 0,       2, 0, 2, 16'h2222, 0, 1, 0);
        // kill of a queued entry
        addv(1, 4, 16'h4444, 1, 9, 16'hAAAA, 9, 1, 4, 16'h4444, 1, 1, 1);
        addv(1, 9, 16'hBBBB, 0, 0, 0,       9, 1, 9, 16'hBBBB, 1, 1, 1);
        addv(0, 0, 0,        0, 0, 0,       9, 0, 9, 16'hBBBB, 0, 1, 0);
        // register 0
        addv(1, 0, 16'h0F0F, 0, 0, 0,   0, !DISC, 0, 16'h0F0F, 0, 1, !DISC);
        addv(0, 0, 0,        0, 0, 0,       0, 0, 0, 16'h0F0F, 0, 1, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_wr", WriteReg, 0);
        chk("rst_cnt", count, 0);
        chk("rst_rdy", mem_ready, 1);
        chk("rst_hit", {pend_hit1, pend_hit2}, 0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].av, vt[i].ar, vt[i].ad, vt[i].mv, vt[i].mr, vt[i].md);
            pend_reg1 = vt[i].pr;
            pend_reg2 = vt[i].pr;
            if (vt[i].ewr) exp_q.push_back({vt[i].edst, vt[i].edata});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr", i), WriteReg, vt[i].ewr);
            chk($sformatf("v%0d_cnt", i), count, vt[i].ecnt);
            chk($sformatf("v%0d_rdy", i), mem_ready, vt[i].erdy);
            chk($sformatf("v%0d_hit1", i), pend_hit1, vt[i].ehit);
            chk($sformatf("v%0d_hit2", i), pend_hit2, vt[i].ehit);
            if (WriteReg) sb_pop();
        end
        chk("tbl_drain", exp_q.size(), 0);
        chk("rf9_final", rf[9], 16'hBBBB);
        chk("rf2_final", rf[2], 16'h2222);
        exp_q.delete();

        // randomised run against a reference queue
        m_wr = 1'b0;
        m_dst = '0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 4, 4'($urandom_range(0, 15)),
                  16'($urandom), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), 16'($urandom));
            pend_reg1 = 4'($urandom_range(0, 15));
            pend_reg2 = 4'($urandom_range(0, 15));
            rdy = mq.size() != DEPTH;
            chk("rnd_rdy", mem_ready, rdy);
            acc = mem_valid && rdy;
            ka  = !(DISC && alu_reg == 0);
            km  = !(DISC && mem_reg == 0);
            byp = 1'b0;
            if (alu_valid) begin
                foreach (mq[k]) if (mq[k].rd == alu_reg) mq[k].live = 1'b0;
                m_wr = ka;
                if (ka) begin
                    m_dst = alu_reg;
                    exp_q.push_back({alu_reg, alu_data});
                end
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_wr = e.live;
                if (e.live) begin
                    m_dst = e.rd;
                    exp_q.push_back({e.rd, e.data});
                end
            end else if (acc) begin
                byp = 1'b1;
                m_wr = km;
                if (km) begin
                    m_dst = mem_reg;
                    exp_q.push_back({mem_reg, mem_data});
                end
            end else begin
                m_wr = 1'b0;
            end
            if (acc && !byp && km)
                mq.push_back('{rd: mem_reg, data: mem_data,
                               live: !(alu_valid && alu_reg == mem_reg)});
            @(posedge clk);
            #1;
            chk("rnd_wr", WriteReg, m_wr);
            chk("rnd_cnt", count, mq.size());
            mhit = m_wr && m_dst == pend_reg1;
            foreach (mq[k]) if (mq[k].live && mq[k].rd == pend_reg1) mhit = 1;
            if (DISC && pend_reg1 == 0) mhit = 1'b0;
            chk("rnd_hit1", pend_hit1, mhit);
            if (WriteReg) sb_pop();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live) exp_q.push_back({e.rd, e.data});
            end
            @(posedge clk);
            #1;
            if (WriteReg) sb_pop();
        end
        chk("rnd_drain", exp_q.size(), 0);
        exp_q.delete();

        // asynchronous reset with three queued entries and a write in flight
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 16'h00C0, 1, 4'(10 + c), 16'h0C00);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        pend_reg1 = 10;
        pend_reg2 = 1;
        chk("pre_rst_cnt", count, 3);
        chk("pre_rst_wr", WriteReg, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr", WriteReg, 0);
        chk("async_rst_cnt", count, 0);
        chk("async_rst_rdy", mem_ready, 1);
        chk("async_rst_hit", {pend_hit1, pend_hit2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_wr", WriteReg, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Merges the two writeback sources of the pipeline into the single register-file write port: ALU results (fixed timing, never stalled) and memory-load results (variable timing, ready/valid). ALU results have priority. Deferred load results wait in a small in-order queue. The block drives `DstReg`/`WriteReg`/`DstData` of the register file from a registered output stage. It also exposes a pending-write scoreboard so decode can detect reads of registers whose writes are not yet committed.

## Interface
Parameters:
- `DEPTH`, default 4: load-result queue entries; power of two, ≥2.
- `DATA_W`, default 16: data width.
- `REG_W`, default 4: register index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result present; always accepted.
- `alu_reg` in REG_W, `alu_data` in DATA_W: ALU destination and result.
- `mem_valid` in 1, `mem_ready` out 1: load-result handshake.
- `mem_reg` in REG_W, `mem_data` in DATA_W: load destination and data.
- `DstReg` out REG_W, `WriteReg` out 1, `DstData` out DATA_W: register-file write port, registered.
- `pend_reg1`, `pend_reg2` in REG_W: scoreboard lookup indices.
- `pend_hit1`, `pend_hit2` out 1: a live uncommitted write targets that register.
- `count` out $clog2(DEPTH)+1: occupied queue entries, including killed ones.

## Operation
- Output-stage selection at each edge, in priority order:
  - `alu_valid`: load the ALU write.
  - Else, queue non-empty: pop the head. `WriteReg` = the head's live bit.
  - Else, `mem_valid` with queue empty: bypass the load directly to the output stage.
  - Else: `WriteReg`←0. `DstReg`/`DstData` hold their values.
- Handshakes and queue entry:
  - Accept occurs when `mem_valid & mem_ready`.
  - An accepted load that is not bypassed is pushed with live=1.
  - `mem_ready = (count != DEPTH)`. It is never a function of the same-cycle pop or of `alu_valid`.
  - The queue is strict FIFO with wrap-around read/write pointers. Full and empty are distinguished by `count`.
- Age rules:
  - Queued entries are older than any ALU result.
  - A load presented in the same cycle as an ALU result is older than that result.
- Kill rule: when `alu_valid`, every queue entry with reg == `alu_reg` gets live←0. A same-cycle accepted load with `mem_reg == alu_reg` is pushed already dead. Killed entries still occupy a slot. Their pop produces no write.
- Scoreboard: `pend_hitN` = 1 when either of these holds:
  - A live queue entry matches `pend_regN`.
  - `WriteReg` is 1 and `DstReg == pend_regN`.
  
  The scoreboard output is combinational from state.
- Reset: queue emptied and `count`=0. `WriteReg`=0, `DstReg`=0, `DstData`=0, `pend_hit*`=0, `mem_ready`=1.

## Timing
- ALU result: `WriteReg` is high the cycle after `alu_valid`. The register file captures it at the following edge.
- Bypassed load: latency 1 cycle. Queued load: 1 cycle plus the number of cycles the queue head waits behind ALU writes and older entries.
- Throughput: at most one register-file write per cycle. Sustained `alu_valid` starves the queue indefinitely. This is acceptable, because the pipeline guarantees ALU gaps.
- Push and pop in the same cycle (not full): `count` is unchanged.
- Full and popping: the push is refused that cycle, since `mem_ready`=0. It is accepted next cycle.
- `rst_n` asserted mid-operation: all queued and output-stage writes are discarded immediately, without waiting for an edge.

## Configuration
- `WB_R0_DISCARD_EN` defined:
  - Writes targeting register 0 from either source are handshaken but dropped.
  - They are never queued, never assert `WriteReg`, and never set `pend_hit`.
  - A lookup of register 0 returns `pend_hit`=0.
- Undefined: register 0 is treated like any other register.

## Structure
- Shared package `wb_pkg` holds:
  - the `DATA_W`/`REG_W` constants;
  - the queue entry typedef {reg, data, live};
  - the register-0 index constant.
- One sub-module, `wb_fifo`: a circular buffer with per-entry live bits, a parallel kill-by-register port, and match outputs for the scoreboard. The top level contains selection, bypass and the output register.

## Test plan
- Reset: assert `rst_n`=0 with 3 entries queued and `WriteReg`=1 → immediately `WriteReg`=0, `count`=0, `mem_ready`=1, `pend_hit*`=0.
- Single ALU write (`alu_reg`=3, `alu_data`=0x1234) → next cycle `DstReg`=3, `DstData`=0x1234, `WriteReg`=1 for exactly one cycle. `pend_hit1` with `pend_reg1`=3 is high that cycle.
- Queue fill (`DEPTH`=4): `alu_valid` for 6 cycles while loads to regs 5, 6, 7, 8, 9 are offered →
  - `mem_ready`=0 once `count`=4, and reg 9 waits;
  - after the ALU stops, writes occur to 5, 6, 7, 8, 9 on consecutive cycles.
- Kill: queue holds reg 9 = 0xAAAA, then ALU writes reg 9 = 0xBBBB → the pop of the reg-9 entry gives `WriteReg`=0. Register 9 ends at 0xBBBB. `pend_hit` for 9 goes low after the ALU write commits.
- Same-cycle conflict: with the queue empty, a load (reg 2, 0x1111) and an ALU result (reg 2, 0x2222) arrive together → the handshake completes and only 0x2222 is written. The dead entry pops one cycle later with `WriteReg`=0.
- Macro: ALU write to reg 0 → with `WB_R0_DISCARD_EN`, `WriteReg` stays 0. Without it, `WriteReg`=1 and `DstReg`=0.
